// File: rtl/keypad_scanner_if.sv
// Key output channel of the keypad scanner: accepted code, valid/ready handshake, sticky overrun.
// Master side is the scanner, slave side is the key consumer.
// The consumer pulls a key by holding key_ready high while key_valid is high.
interface keypad_scanner_if;
   logic [3:0] key_code;
   logic       key_valid;
   logic       key_ready;
   logic       overrun;

   modport master (
      output key_code,
      output key_valid,
      output overrun,
      input  key_ready
   );

   modport slave (
      input  key_code,
      input  key_valid,
      input  overrun,
      output key_ready
   );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: strobes columns, debounces the row sense lines, reports one code per press.
// Latency: key_code/key_valid update one clk after the accepting sample point (rows see 2 extra syncs).
// Backpressure: an unconsumed key is held stable; a new key arriving then is dropped and overrun sticks.
module keypad_scanner #(
   parameter int SCAN_TICKS     = 1000,
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [3:0]       row_i,
   output logic [3:0]       col_o,
   keypad_scanner_if.master key_if
);

   localparam int TW = $clog2(SCAN_TICKS);
   localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
   localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_TICKS - 1);
   localparam logic [CW-1:0] CNT_DONE  = CW'(DEBOUNCE_SCANS);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);

   typedef enum logic [1:0] {
      SCAN    = 2'd0,
      CONFIRM = 2'd1,
      RELEASE = 2'd2
   } state_t;

   logic [3:0]    sync_meta_q;
   logic [3:0]    rs_q;
   logic [TW-1:0] tick_q;
   state_t        state_q, state_d;
   logic [1:0]    col_q, col_d;
   logic [1:0]    row_q, row_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [3:0]    col_o_q;
   logic [3:0]    key_code_q;
   logic          key_valid_q;
   logic          overrun_q;

   logic          sample;
   logic          rs_idle;
   logic [1:0]    rs_low;
   logic          accept;
   logic [3:0]    acc_code;

   // Lowest-index row reading low; only meaningful when some row is low.
   function automatic logic [1:0] lowest_low(input logic [3:0] r);
      if (!r[0])      return 2'd0;
      else if (!r[1]) return 2'd1;
      else if (!r[2]) return 2'd2;
      else            return 2'd3;
   endfunction

   assign sample  = (tick_q == TICK_LAST);
   assign rs_idle = (rs_q == 4'b1111);
   assign rs_low  = lowest_low(rs_q);

   // Two-flop synchronizer for the asynchronous row lines; idles high like the pull-ups.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_meta_q <= 4'b1111;
         rs_q        <= 4'b1111;
      end else begin
         sync_meta_q <= row_i;
         rs_q        <= sync_meta_q;
      end
   end

   // Dwell counter: free-running 0..SCAN_TICKS-1, the last count is the row sample point.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tick_q <= '0;
      end else if (sample) begin
         tick_q <= '0;
      end else begin
         tick_q <= tick_q + TW'(1);
      end
   end

   // Scan/debounce decisions, taken only at sample points; column is held while a key is in play.
   always_comb begin
      state_d  = state_q;
      col_d    = col_q;
      row_d    = row_q;
      cnt_d    = cnt_q;
      accept   = 1'b0;
      acc_code = {row_q, col_q};
      if (sample) begin
         case (state_q)
            SCAN: begin
               if (rs_idle) begin
                  col_d = col_q + 2'd1;
               end else begin
                  row_d    = rs_low;
                  acc_code = {rs_low, col_q};
                  if (CNT_DONE == CNT_ONE) begin
                     accept  = 1'b1;
                     cnt_d   = '0;
                     state_d = RELEASE;
                  end else begin
                     cnt_d   = CNT_ONE;
                     state_d = CONFIRM;
                  end
               end
            end
            CONFIRM: begin
               if (!rs_idle && rs_low == row_q) begin
                  if (cnt_q + CNT_ONE == CNT_DONE) begin
                     accept  = 1'b1;
                     cnt_d   = '0;
                     state_d = RELEASE;
                  end else begin
                     cnt_d = cnt_q + CNT_ONE;
                  end
               end else begin
                  // Bounce or a different key: drop the candidate and move on.
                  cnt_d   = '0;
                  col_d   = col_q + 2'd1;
                  state_d = SCAN;
               end
            end
            RELEASE: begin
               if (rs_idle) begin
                  if (cnt_q + CNT_ONE == CNT_DONE) begin
                     cnt_d   = '0;
                     col_d   = col_q + 2'd1;
                     state_d = SCAN;
                  end else begin
                     cnt_d = cnt_q + CNT_ONE;
                  end
               end else begin
                  cnt_d = '0;
               end
            end
            default: begin
               cnt_d   = '0;
               state_d = SCAN;
            end
         endcase
      end
   end

   // State, column, latched row and stable count registers; col_o is re-encoded from the next column.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= SCAN;
         col_q   <= 2'd0;
         row_q   <= 2'd0;
         cnt_q   <= '0;
         col_o_q <= 4'b1110;
      end else begin
         state_q <= state_d;
         col_q   <= col_d;
         row_q   <= row_d;
         cnt_q   <= cnt_d;
         col_o_q <= ~(4'b0001 << col_d);
      end
   end

   // Output handshake: hold an unconsumed key, drop newcomers into the sticky overrun flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         key_code_q  <= 4'h0;
         key_valid_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else if (accept) begin
         if (!key_valid_q || key_if.key_ready) begin
            key_code_q  <= acc_code;
            key_valid_q <= 1'b1;
         end else begin
            overrun_q <= 1'b1;
         end
      end else if (key_valid_q && key_if.key_ready) begin
         key_valid_q <= 1'b0;
      end
   end

   assign col_o            = col_o_q;
   assign key_if.key_code  = key_code_q;
   assign key_if.key_valid = key_valid_q;
   assign key_if.overrun   = overrun_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: emulated 4x4 key matrix, directed scenario table, hand sequences, random presses.
// Every clock is checked against a sample-level reference model of the scan/debounce/handshake rules.
// Runs with SCAN_TICKS=4, DEBOUNCE_SCANS=2.
module tb_keypad_scanner;
   localparam int ST = 4;
   localparam int DB = 2;
   localparam int NV = 5;

   logic       clk;
   logic       rst_n;
   logic [3:0] row_i;
   logic [3:0] col_o;

   keypad_scanner_if kif();

   keypad_scanner #(
      .SCAN_TICKS    (ST),
      .DEBOUNCE_SCANS(DB)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .row_i (row_i),
      .col_o (col_o),
      .key_if(kif.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;

   // Keys currently held down, bit index row*4+col.
   logic [15:0] mask;

   // Reference model state.
   int         m_edges;
   int         m_col;
   int         m_cand;
   int         m_run;
   bit         m_rel;
   bit         m_v;
   bit         m_ovr;
   logic [3:0] m_code;

   // Observation statistics for the directed table.
   int         pulses;
   int         vcyc;
   logic [3:0] last_code;
   bit         prev_v;

   typedef struct {
      string       name;
      logic [15:0] m0;
      int          s0;
      int          e0;
      logic [15:0] m1;
      int          s1;
      int          e1;
      int          total;
      int          rdy;
      int          exp_pulses;
      int          exp_vcyc;
      logic [3:0]  exp_code;
      bit          exp_v;
      bit          exp_ovr;
   } vec_t;

   vec_t tbl[NV];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Physical matrix: a row reads low when a pressed key joins it to a driven-low column.
   function automatic logic [3:0] keypad_rows(input logic [15:0] m, input logic [3:0] cols);
      logic [3:0] r;
      r = 4'b1111;
      for (int rr = 0; rr < 4; rr++)
         for (int c = 0; c < 4; c++)
            if (!cols[c] && m[rr*4+c]) r[rr] = 1'b0;
      return r;
   endfunction

   task automatic model_reset();
      m_edges = 0;
      m_col   = 0;
      m_cand  = -1;
      m_run   = 0;
      m_rel   = 1'b0;
      m_v     = 1'b0;
      m_ovr   = 1'b0;
      m_code  = 4'h0;
   endtask

   // One clock edge of the reference: every ST-th edge looks at the keypad under the current column.
   task automatic model_edge(input logic [15:0] m, input bit rdy);
      int         acc;
      int         low;
      logic [3:0] rw;
      logic [3:0] colsel;
      acc = -1;
      low = -1;
      if (m_edges % ST == ST - 1) begin
         colsel = 4'b1111;
         colsel[m_col] = 1'b0;
         rw = keypad_rows(m, colsel);
         for (int r = 3; r >= 0; r--) if (!rw[r]) low = r;
         if (m_rel) begin
            m_run = (low < 0) ? m_run + 1 : 0;
            if (m_run == DB) begin
               m_rel = 1'b0;
               m_run = 0;
               m_col = (m_col + 1) % 4;
            end
         end else if (m_cand < 0) begin
            if (low < 0) m_col = (m_col + 1) % 4;
            else begin
               m_cand = low * 4 + m_col;
               m_run  = 1;
            end
         end else if (low == m_cand / 4) begin
            m_run++;
         end else begin
            m_cand = -1;
            m_run  = 0;
            m_col  = (m_col + 1) % 4;
         end
         if (m_cand >= 0 && m_run == DB) begin
            acc    = m_cand;
            m_cand = -1;
            m_run  = 0;
            m_rel  = 1'b1;
         end
      end
      m_edges++;
      if (acc >= 0) begin
         if (!m_v || rdy) begin
            m_code = 4'(acc);
            m_v    = 1'b1;
         end else begin
            m_ovr = 1'b1;
         end
      end else if (m_v && rdy) begin
         m_v = 1'b0;
      end
   endtask

   // One clock: drive from the falling edge, compare everything just after the rising edge.
   task automatic cycle(input bit rdy);
      logic [3:0] one;
      logic [3:0] ec;
      one           = 4'b0001;
      kif.key_ready = rdy;
      row_i         = keypad_rows(mask, col_o);
      @(posedge clk);
      model_edge(mask, rdy);
      #1;
      ec = ~(one << m_col);
      check("col_o",     32'(col_o),         32'(ec));
      check("key_valid", 32'(kif.key_valid), 32'(m_v));
      check("key_code",  32'(kif.key_code),  32'(m_code));
      check("overrun",   32'(kif.overrun),   32'(m_ovr));
      if (kif.key_valid) begin
         vcyc++;
         last_code = kif.key_code;
         if (!prev_v) pulses++;
      end
      prev_v = kif.key_valid;
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n         = 1'b0;
      mask          = 16'h0;
      kif.key_ready = 1'b0;
      row_i         = 4'hF;
      repeat (3) @(negedge clk);
      check("rst_col_o",     32'(col_o),         32'(4'b1110));
      check("rst_key_valid", 32'(kif.key_valid), 32'(0));
      check("rst_key_code",  32'(kif.key_code),  32'(0));
      check("rst_overrun",   32'(kif.overrun),   32'(0));
      rst_n = 1'b1;
      model_reset();
      prev_v    = 1'b0;
      pulses    = 0;
      vcyc      = 0;
      last_code = 4'h0;
   endtask

   task automatic run_table();
      logic [15:0] m;
      for (int i = 0; i < NV; i++) begin
         do_reset();
         for (int d = 0; d < tbl[i].total; d++) begin
            m = 16'h0;
            if (d >= tbl[i].s0 && d < tbl[i].e0) m = m | tbl[i].m0;
            if (d >= tbl[i].s1 && d < tbl[i].e1) m = m | tbl[i].m1;
            mask = m;
            repeat (ST) cycle(bit'(tbl[i].rdy));
         end
         check({tbl[i].name, "_pulses"},  32'(pulses),        32'(tbl[i].exp_pulses));
         check({tbl[i].name, "_vcycles"}, 32'(vcyc),          32'(tbl[i].exp_vcyc));
         check({tbl[i].name, "_code"},    32'(last_code),     32'(tbl[i].exp_code));
         check({tbl[i].name, "_valid"},   32'(kif.key_valid), 32'(tbl[i].exp_v));
         check({tbl[i].name, "_overrun"}, 32'(kif.overrun),   32'(tbl[i].exp_ovr));
      end
   endtask

   initial begin
      logic [3:0]  one;
      logic [3:0]  ec;
      logic [15:0] m;
      int          k;
      int          nd;
      int          rm;

      rst_n         = 1'b0;
      mask          = 16'h0;
      row_i         = 4'hF;
      kif.key_ready = 1'b0;
      one           = 4'b0001;

      //            name       m0       s0 e0 m1       s1 e1 tot rdy pul vcyc code v  ovr
      tbl[0] = '{"idle",     16'h0000, 0, 0, 16'h0000, 0, 0, 16, 1, 0, 0,  4'h0, 0, 0};
      tbl[1] = '{"key6",     16'h0040, 0, 8, 16'h0000, 0, 0, 14, 1, 1, 1,  4'h6, 0, 0};
      tbl[2] = '{"bounce",   16'h0200, 1, 2, 16'h0000, 0, 0, 6,  1, 0, 0,  4'h0, 0, 0};
      tbl[3] = '{"rows03",   16'h2002, 0, 6, 16'h0000, 0, 0, 12, 1, 1, 1,  4'h1, 0, 0};
      tbl[4] = '{"overrun",  16'h0001, 0, 5, 16'h8000, 8, 14, 16, 0, 1, 57, 4'h0, 1, 1};

      // Idle scan: each column strobed for ST clocks in order, nothing reported.
      do_reset();
      for (int n = 1; n <= 64; n++) begin
         cycle(1'b1);
         ec = ~(one << ((n / 4) % 4));
         check("idle_col", 32'(col_o), 32'(ec));
         check("idle_valid", 32'(kif.key_valid), 32'(0));
      end

      run_table();

      // Bounce: scanning must move on to column 2 right after the discarding sample.
      do_reset();
      mask = 16'h0;
      repeat (ST) cycle(1'b1);
      mask = 16'h0200;
      repeat (ST) cycle(1'b1);
      mask = 16'h0;
      repeat (ST) cycle(1'b1);
      check("bounce_next_col", 32'(col_o), 32'(4'b1011));

      // Reset in the middle of a CONFIRM on column 2: outputs drop at once, press is forgotten.
      do_reset();
      mask = 16'h0400;
      repeat (3 * ST) cycle(1'b1);
      cycle(1'b1);
      check("confirm_col_held", 32'(col_o), 32'(4'b1011));
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_col", 32'(col_o), 32'(4'b1110));
      check("async_rst_valid", 32'(kif.key_valid), 32'(0));
      check("async_rst_code", 32'(kif.key_code), 32'(0));
      do_reset();
      repeat (8 * ST) cycle(1'b1);
      check("after_rst_pulses", 32'(pulses), 32'(0));

      // Random presses, bounces, chords and consumer stalls.
      do_reset();
      for (int seg = 0; seg < 120; seg++) begin
         if (seg == 60) do_reset();
         k = $urandom_range(0, 9);
         if (k < 5) m = 16'h0;
         else if (k < 9) m = 16'h1 << $urandom_range(0, 15);
         else m = (16'h1 << $urandom_range(0, 15)) | (16'h1 << $urandom_range(0, 15));
         nd   = $urandom_range(1, 6);
         rm   = ($urandom_range(0, 4) == 0) ? 0 : 2;
         mask = m;
         repeat (nd * ST) cycle((rm == 2) ? ($urandom_range(0, 3) != 0) : 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter SCAN_TICKS, default 1000, clk cycles each column strobe is held (dwell); legal range >= 2.
REQ-002 Parameter DEBOUNCE_SCANS, default 4, consecutive equal dwell samples required to accept a press or a release; legal range >= 1.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset; deassertion synchronous to clk.
REQ-005 row_i  input  4  keypad rows, active-low (pulled up), asynchronous to clk.
REQ-006 col_o  output  4  keypad column strobes, active-low one-hot, registered.
REQ-007 key_code  output  4  accepted key, code = row_index*4 + col_index.
REQ-008 key_valid  output  1  key_code holds an unconsumed key.
REQ-009 key_ready  input  1  consumer accepts key_code when key_valid=1 and key_ready=1.
REQ-010 overrun  output  1  sticky flag; a key was accepted while key_valid=1 and not being consumed.

Function
REQ-011 row_i shall pass through a 2-flop synchronizer; all decisions use the synchronized value (rs).
REQ-012 A dwell counter shall count 0..SCAN_TICKS-1 and wrap; the sample point is the cycle the counter equals SCAN_TICKS-1.
REQ-013 FSM states SCAN, CONFIRM, RELEASE; reset state SCAN.
REQ-014 SCAN: at each sample point, if rs = 4'b1111, col_o rotates to the next column (0->1->2->3->0) on the following edge.
REQ-015 SCAN: at a sample point with any rs bit low, latch row = lowest-index low bit, col = current column, set stable count to 1, hold column, go CONFIRM (go directly to accept if DEBOUNCE_SCANS = 1).
REQ-016 CONFIRM: at each sample point, if the latched row is still the lowest low bit, increment count; at count = DEBOUNCE_SCANS accept the key and go RELEASE.
REQ-017 CONFIRM: at a sample point with a different row pattern or all high, discard, go SCAN, advance to next column.
REQ-018 Accept: key_code and key_valid update on the edge after the accepting sample point (latency 1 cycle).
REQ-019 Accept with key_valid=0, or with key_valid=1 and key_ready=1 on the same cycle: load the new code, key_valid=1, no overrun.
REQ-020 Accept with key_valid=1 and key_ready=0: new code dropped, old key_code kept, overrun set to 1.
REQ-021 key_valid, once set, shall remain 1 with key_code stable until a cycle with key_ready=1; it clears on the next edge.
REQ-022 RELEASE: column held; count consecutive sample points with rs = 4'b1111; any low sample resets count to 0; at DEBOUNCE_SCANS go SCAN and advance to next column.
REQ-023 Only one key per press shall be reported; no auto-repeat while held.
REQ-024 Dwell counter and stable count saturate/wrap only within their ranges; widths sized by $clog2 of the parameters.

Reset
REQ-025 While rst_n=0: col_o=4'b1110, key_code=4'h0, key_valid=0, overrun=0, state SCAN, all counters 0, synchronizer flops 1.
REQ-026 Reset asserted mid-CONFIRM or RELEASE shall abandon the press immediately; no key is reported for it after reset.
REQ-027 overrun shall clear only on reset.

Verification (SCAN_TICKS=4, DEBOUNCE_SCANS=2)
REQ-028 No key pressed, 64 cycles -> col_o cycles 1110,1101,1011,0111 with 4 cycles each, key_valid stays 0.
REQ-029 Row 1 held low while col 2 strobed, key_ready=1 -> key_code=4'h6 with key_valid=1 for exactly one cycle, 1 cycle after the 2nd stable sample; no repeat while held.
REQ-030 Row 2 low for one sample only (bounce) -> no key_valid, scan resumes at next column.
REQ-031 Rows 0 and 3 low on col 1 -> key_code=4'h1.
REQ-032 key_ready=0, press col0/row0 then col3/row3 after release -> key_code stays 4'h0, key_valid=1, overrun=1.
REQ-033 rst_n pulsed low during CONFIRM -> outputs at reset values, col_o=4'b1110, no key reported for that press.
